// File: rtl/encoder_pkg.sv
// Shared constants for the matrix encoder stages: geometry, FSM encoding and
// the rho rotation offsets used by rho_rotate_func.
package encoder_pkg;

  localparam int SLICE_W = 25;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = 7;
  localparam int ADDR_W  = 6;

  typedef logic [SLICE_W-1:0] slice_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Indexed by 5*y + x; listed row by row for y = 0..4.
  localparam logic [ADDR_W-1:0] RHO_OFF [SLICE_W] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  // Source slice of lane 'lane' when producing output slice z; 6-bit wrap is intended.
  function automatic logic [ADDR_W-1:0] rho_src_addr(input logic [ADDR_W-1:0] z,
                                                     input int lane);
    return z - RHO_OFF[lane];
  endfunction

endpackage

// File: rtl/rho_ctrl.sv
// Sequencing FSM for the rho stage: IDLE -> LOAD -> WRITE -> DONE -> IDLE.
// Produces the datapath enables; the counter and buffer live in the parent.
module rho_ctrl
  import encoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cnt_co,
  output logic load_en,
  output logic wr_en,
  output logic cnt_en,
  output logic cnt_rst,
  output logic done
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)  state_d = ST_LOAD;
      ST_LOAD:  if (cnt_co) state_d = ST_WRITE;
      ST_WRITE: if (cnt_co) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // All outputs are Moore decodes so nothing glitches on start.
  always_comb begin
    load_en = (state_q == ST_LOAD);
    wr_en   = (state_q == ST_WRITE);
    cnt_en  = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    cnt_rst = (state_q == ST_IDLE) || (state_q == ST_DONE);
    done    = (state_q == ST_DONE);
  end

endmodule

// File: rtl/rho_rotate_func.sv
// Rho stage: buffers the 64 slices of the state, then writes them back with
// every lane rotated along z by its rho offset.
module rho_rotate_func
  import encoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SLICE_W-1:0]  line_in,
  output logic [CNT_W-1:0]    cnt_value,
  output logic                write_enable,
  output logic [SLICE_W-1:0]  write_value,
  output logic                donee
);

  logic load_en;
  logic wr_en;
  logic cnt_en;
  logic cnt_rst;
  logic done;
  logic cnt_co;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  slice_t state_buf_q [DEPTH];
  slice_t state_buf_d [DEPTH];
  slice_t rot_slice;

  rho_ctrl u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cnt_co  (cnt_co),
    .load_en (load_en),
    .wr_en   (wr_en),
    .cnt_en  (cnt_en),
    .cnt_rst (cnt_rst),
    .done    (done)
  );

  assign cnt_co = (cnt_q == CNT_W'(DEPTH - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_rst) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = cnt_co ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_buf_d = state_buf_q;
    if (load_en) begin
      state_buf_d[cnt_q[ADDR_W-1:0]] = line_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      state_buf_q <= '{default: '0};
    end else begin
      cnt_q       <= cnt_d;
      state_buf_q <= state_buf_d;
    end
  end

  // One 64:1 mux per lane bit, each addressed by its own rotated slice index.
  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_lane
    logic [ADDR_W-1:0] src_z;
    assign src_z         = rho_src_addr(cnt_q[ADDR_W-1:0], gi);
    assign rot_slice[gi] = state_buf_q[src_z][gi];
  end

  assign cnt_value    = cnt_q;
  assign write_enable = wr_en;
  assign write_value  = wr_en ? rot_slice : '0;
  assign donee        = done;

endmodule

// File: tb/tb_rho_rotate_func.sv
// Self-checking bench for rho_rotate_func: table vectors, scoreboard of writes,
// random full passes and asynchronous abort sequences.
module tb_rho_rotate_func;

  typedef struct {
    logic [6:0]  z;
    logic [24:0] val;
  } sb_t;

  typedef struct {
    int          src_z;
    int          bit_i;
    int          dst_z;
    logic [24:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] line_in;
  logic [6:0]  cnt_value;
  logic        write_enable;
  logic [24:0] write_value;
  logic        donee;

  logic [24:0] mem [64];
  logic [24:0] got [64];
  logic        rnd_en;
  logic [24:0] rnd_line;

  int off [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                   41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  sb_t sb_q[$];
  sb_t e;
  vec_t vecs [3];

  int checks = 0;
  int failures = 0;
  int neg_cnt = 0;
  int wr_count, done_count, first_wr, done_at;
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  assign line_in = rnd_en ? rnd_line : mem[cnt_value[5:0]];

  rho_rotate_func dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .write_enable (write_enable),
    .write_value  (write_value),
    .donee        (donee)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] rho_ref(input int z);
    logic [24:0] r;
    for (int i = 0; i < 25; i++) begin
      r[i] = mem[((z - off[i]) % 64 + 64) % 64][i];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    neg_cnt++;
    if (sb_on) begin
      if (write_enable) begin
        wr_count++;
        if (first_wr == 0) first_wr = neg_cnt;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow got_z=%0d data=%h", cnt_value, write_value);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(cnt_value), 32'(e.z));
          check("wr_data", 32'(write_value), 32'(e.val));
        end
        got[cnt_value[5:0]] = write_value;
      end else begin
        check("wv_zero_outside_write", 32'(write_value), 32'd0);
      end
      if (donee) begin
        done_count++;
        done_at = neg_cnt;
        check("done_we_low", 32'(write_enable), 32'd0);
      end
    end
  end

  task automatic run_pass(input bit pulses);
    int c0;
    int cyc;
    for (int z = 0; z < 64; z++) got[z] = 25'h1FFFFFF;
    sb_q.delete();
    for (int z = 0; z < 64; z++) sb_q.push_back('{z: 7'(z), val: rho_ref(z)});
    wr_count = 0;
    done_count = 0;
    first_wr = 0;
    done_at = 0;
    sb_on = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = neg_cnt;
    cyc = 0;
    while (done_count == 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (pulses && cyc > 3 && cyc < 120) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
    end
    if (done_count == 0) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout got=no_donee exp=donee_within_300");
    end
    repeat (3) @(posedge clk);
    #1;
    check("write_count", 32'(wr_count), 32'd64);
    check("done_pulses", 32'(done_count), 32'd1);
    check("first_write_latency", 32'(first_wr - c0), 32'd65);
    check("done_latency", 32'(done_at - c0), 32'd129);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("idle_cnt", 32'(cnt_value), 32'd0);
    sb_on = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 32'(cnt_value), 32'd0);
    check({tag, "_we"}, 32'(write_enable), 32'd0);
    check({tag, "_wv"}, 32'(write_value), 32'd0);
    check({tag, "_done"}, 32'(donee), 32'd0);
  endtask

  initial begin
    int nz;
    vecs[0] = '{src_z: 5, bit_i: 0, dst_z: 5, exp: 25'h0000001};
    vecs[1] = '{src_z: 0, bit_i: 1, dst_z: 1, exp: 25'h0000002};
    vecs[2] = '{src_z: 5, bit_i: 2, dst_z: 3, exp: 25'h0000004};
    for (int z = 0; z < 64; z++) mem[z] = '0;

    // Test 1: reset with random inputs, then idle without start.
    rst = 1'b0;
    start = 1'b0;
    rnd_en = 1'b1;
    rnd_line = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rnd_line = 25'($urandom);
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    start = 1'b0;
    rnd_en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all_zero("idle_no_start");
    end

    // Tests 2-4: single-bit table vectors.
    for (int v = 0; v < 3; v++) begin
      for (int z = 0; z < 64; z++) mem[z] = '0;
      mem[vecs[v].src_z][vecs[v].bit_i] = 1'b1;
      run_pass(1'b0);
      check($sformatf("vec%0d_dst", v), 32'(got[vecs[v].dst_z]), 32'(vecs[v].exp));
      nz = 0;
      for (int z = 0; z < 64; z++) if (z != vecs[v].dst_z && got[z] !== 25'd0) nz++;
      check($sformatf("vec%0d_others_nonzero", v), 32'(nz), 32'd0);
      $display("vec %0d: src_z=%0d bit=%0d dst_z=%0d out=%h", v, vecs[v].src_z,
               vecs[v].bit_i, vecs[v].dst_z, got[vecs[v].dst_z]);
    end

    // Test 5: random state with stray start pulses during LOAD/WRITE.
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    run_pass(1'b1);
    $display("random pass with start pulses: writes=%0d", wr_count);

    // Test 6a: abort in LOAD cycle 30.
    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    check("abort_load_cnt_nonzero", 32'(cnt_value != 7'd0), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("abort_load");
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("after_abort_load");

    // Test 6b: abort in WRITE cycle 10.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (73) @(posedge clk);
    #2;
    check("abort_write_we_high", 32'(write_enable), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("abort_write");
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
    run_pass(1'b0);
    $display("clean pass after aborts: writes=%0d", wr_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
